// File: rtl/tensor_pkg.sv
// Shared types and constants for the tensor-block weight loader.
//   LANES / DW / ROWS : row geometry (10 int8 lanes, 3 rows per bank set)
//   ROW_W             : bits per row
//   IDX_W / LAST_IDX  : row index width and index of the final row of a set
//   bank_state_t      : per-bank lifecycle
//   emit_state_t      : load-sequence emitter phases
//   row_t             : one weight row
package tensor_pkg;

  localparam int LANES = 10;
  localparam int DW    = 8;
  localparam int ROWS  = 3;
  localparam int ROW_W = LANES * DW;
  localparam int IDX_W = $clog2(ROWS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [2:0] {
    EMPTY,
    FILLING,
    PENDING,
    LOADING,
    LOADED
  } bank_state_t;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    D0,
    D1,
    D2
  } emit_state_t;

  // A bank can take rows only while it is empty or partially filled.
  function automatic logic can_accept(input bank_state_t st);
    return (st == EMPTY) || (st == FILLING);
  endfunction

endpackage

// File: rtl/tensor_row_set_buf.sv
// Three-row register file for one weight bank.
// Rows are written in order 0..ROWS-1 by an internal write index that wraps
// after the last row, so every set starts at row 0. Reset clears the index,
// which discards any partially written set.
//   clk, rst_n : clock, synchronous active-low reset
//   i_we       : write the row on i_data at the current index
//   i_data     : incoming row
//   o_wr_idx   : index the next write will use
//   o_rows     : all stored rows, row r at [r*ROW_W +: ROW_W]
module tensor_row_set_buf
  import tensor_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [ROW_W-1:0]        i_data,
  output logic [IDX_W-1:0]        o_wr_idx,
  output logic [ROWS*ROW_W-1:0]   o_rows
);

  logic [IDX_W-1:0] r_wr_idx;
  row_t             r_rows [ROWS];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_idx <= '0;
    end else if (i_we) begin
      r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IDX_W'(1);
    end
  end

  // NOTE: row storage has no reset; it is only read after a full set has
  // been written, so clearing it would cost reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_rows[r_wr_idx] <= i_data;
    end
  end

  assign o_wr_idx = r_wr_idx;

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    assign o_rows[g*ROW_W +: ROW_W] = r_rows[g];
  end

endmodule

// File: rtl/tensor_bank_loader.sv
// Weight feeder for the tensor-block column array. Rows arrive on a
// valid/ready stream and fill two ping-ponged banks of three rows; each full
// bank is replayed to the tensor block as a contiguous load sequence.
//   clk, rst_n   : clock, synchronous active-low reset
//   s_valid      : input row valid
//   s_ready      : row accepted when s_valid && s_ready
//   s_data       : input row, lane 0 in bits [7:0]
//   bank_release : per-bank pulse from compute side, frees a LOADED bank
//   load_bank_1  : bank-1 load strobe (data follows next cycle)
//   load_bank_2  : bank-2 load strobe
//   cascade_in   : row data to the tensor block
//   bank_loaded  : bank holds loaded weights
// Bank index 0 is bank 1, index 1 is bank 2. All outputs are registered.
module tensor_bank_loader
  import tensor_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [ROW_W-1:0]   s_data,
  input  logic [1:0]         bank_release,
  output logic               load_bank_1,
  output logic               load_bank_2,
  output logic [ROW_W-1:0]   cascade_in,
  output logic [1:0]         bank_loaded
);

  bank_state_t r_bank_st [2];
  bank_state_t w_bank_st_nxt [2];
  emit_state_t r_emit, w_emit_nxt;
  logic        r_wr_bank, w_wr_bank_nxt;
  logic        r_rd_bank, w_rd_bank_nxt;
  // Set while D2 of one bank doubles as LEAD of the other bank.
  logic        r_chain, w_chain_nxt;
  logic [1:0]  w_start;
  logic [1:0]  w_done;

  logic                  w_accept;
  logic [1:0]            w_we;
  logic [IDX_W-1:0]      w_wr_idx [2];
  logic [IDX_W-1:0]      w_cur_idx;
  logic [ROWS*ROW_W-1:0] w_rows [2];
  logic [ROWS*ROW_W-1:0] w_sel_rows;

  logic       r_s_ready, w_s_ready_nxt;
  logic [1:0] r_load, w_load_nxt;
  row_t       r_cascade, w_cascade_nxt;
  logic [1:0] r_loaded, w_loaded_nxt;

  assign w_accept  = s_valid && r_s_ready;
  assign w_cur_idx = w_wr_idx[r_wr_bank];
  assign w_we[0]   = w_accept && (r_wr_bank == 1'b0);
  assign w_we[1]   = w_accept && (r_wr_bank == 1'b1);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    tensor_row_set_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_we[g]),
      .i_data   (s_data),
      .o_wr_idx (w_wr_idx[g]),
      .o_rows   (w_rows[g])
    );
  end

  // State register: emitter, bank states, pointers and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_emit    <= IDLE;
      r_chain   <= 1'b0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        r_bank_st[b] <= EMPTY;
      end
      r_s_ready <= 1'b0;
      r_load    <= '0;
      r_cascade <= '0;
      r_loaded  <= '0;
    end else begin
      r_emit    <= w_emit_nxt;
      r_chain   <= w_chain_nxt;
      r_wr_bank <= w_wr_bank_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      for (int b = 0; b < 2; b++) begin
        r_bank_st[b] <= w_bank_st_nxt[b];
      end
      r_s_ready <= w_s_ready_nxt;
      r_load    <= w_load_nxt;
      r_cascade <= w_cascade_nxt;
      r_loaded  <= w_loaded_nxt;
    end
  end

  // Emitter next state. rd_bank names the bank being emitted from LEAD to
  // D2 and only advances when D2 is left. The follow-on bank is checked in
  // D1 so its LEAD strobe lands in the same cycle as the current D2 row.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_emit_nxt    = r_emit;
    w_rd_bank_nxt = r_rd_bank;
    w_chain_nxt   = 1'b0;
    w_start       = '0;
    w_done        = '0;
    case (r_emit)
      IDLE: begin
        if (r_bank_st[r_rd_bank] == PENDING) begin
          w_emit_nxt         = LEAD;
          w_start[r_rd_bank] = 1'b1;
        end
      end
      LEAD: w_emit_nxt = D0;
      D0:   w_emit_nxt = D1;
      D1: begin
        w_emit_nxt = D2;
        if (r_bank_st[~r_rd_bank] == PENDING) begin
          w_chain_nxt         = 1'b1;
          w_start[~r_rd_bank] = 1'b1;
        end
      end
      D2: begin
        w_done[r_rd_bank] = 1'b1;
        w_rd_bank_nxt     = ~r_rd_bank;
        if (r_chain) begin
          w_emit_nxt = D0;
        end else if (r_bank_st[~r_rd_bank] == PENDING) begin
          w_emit_nxt          = LEAD;
          w_start[~r_rd_bank] = 1'b1;
        end else begin
          w_emit_nxt = IDLE;
        end
      end
      default: w_emit_nxt = IDLE;
    endcase
  end

  // Bank next state. Accept, emit and release each require a distinct
  // current state, so they never compete for the same bank.
  always_comb begin
    w_wr_bank_nxt = r_wr_bank;
    if (w_accept && (w_cur_idx == LAST_IDX)) begin
      w_wr_bank_nxt = ~r_wr_bank;
    end
    for (int b = 0; b < 2; b++) begin
      w_bank_st_nxt[b] = r_bank_st[b];
      if (w_we[b] && (w_cur_idx == '0)) begin
        w_bank_st_nxt[b] = FILLING;
      end
      if (w_we[b] && (w_cur_idx == LAST_IDX)) begin
        w_bank_st_nxt[b] = PENDING;
      end
      if (w_start[b]) begin
        w_bank_st_nxt[b] = LOADING;
      end
      if (w_done[b]) begin
        w_bank_st_nxt[b] = LOADED;
      end
      if (bank_release[b] && (r_bank_st[b] == LOADED)) begin
        w_bank_st_nxt[b] = EMPTY;
      end
    end
  end

  // Output decode from next state, so the registered outputs line up with
  // the state the machine enters on the same edge.
  always_comb begin
    w_s_ready_nxt = can_accept(w_bank_st_nxt[w_wr_bank_nxt]);
    w_sel_rows    = w_rows[w_rd_bank_nxt];
    for (int b = 0; b < 2; b++) begin
      w_loaded_nxt[b] = (w_bank_st_nxt[b] == LOADED);
      w_load_nxt[b]   = ((w_emit_nxt == LEAD || w_emit_nxt == D0 || w_emit_nxt == D1)
                         && (w_rd_bank_nxt == b[0]))
                     || ((w_emit_nxt == D2) && w_chain_nxt && (w_rd_bank_nxt != b[0]));
    end
    case (w_emit_nxt)
      D0:      w_cascade_nxt = w_sel_rows[0*ROW_W +: ROW_W];
      D1:      w_cascade_nxt = w_sel_rows[1*ROW_W +: ROW_W];
      D2:      w_cascade_nxt = w_sel_rows[2*ROW_W +: ROW_W];
      default: w_cascade_nxt = '0;
    endcase
  end

  assign s_ready     = r_s_ready;
  assign load_bank_1 = r_load[0];
  assign load_bank_2 = r_load[1];
  assign cascade_in  = r_cascade;
  assign bank_loaded = r_loaded;

endmodule

// File: tb/tb_tensor_bank_loader.sv
// Directed bench for tensor_bank_loader. Inputs change 1 time unit after a
// rising edge; outputs are sampled at that same point, i.e. they show the
// registered values produced by the preceding edge.
module tb_tensor_bank_loader;
  import tensor_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  row_t       s_data;
  logic [1:0] bank_release;
  logic       load_bank_1;
  logic       load_bank_2;
  row_t       cascade_in;
  logic [1:0] bank_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tensor_bank_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .bank_release (bank_release),
    .load_bank_1  (load_bank_1),
    .load_bank_2  (load_bank_2),
    .cascade_in   (cascade_in),
    .bank_loaded  (bank_loaded)
  );

  function automatic row_t rv(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {LANES{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d, input logic [1:0] rel);
    s_valid      = v;
    s_data       = rv(d);
    bank_release = rel;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 0, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Sends one 3-row set on consecutive cycles; returns just after row 2's edge.
  task automatic send_set(input int a, input int b, input int c);
    drive(1'b1, a, 2'b00); tick();
    drive(1'b1, b, 2'b00); tick();
    drive(1'b1, c, 2'b00); tick();
    drive(1'b0, 0, 2'b00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'h55, 2'b11);
    tick();
    tick();
    n_tests++;
    if ({s_ready, load_bank_1, load_bank_2, bank_loaded} !== 5'b0 || cascade_in !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want all 0",
               s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in);
    end
    rst_n = 1'b1;
    drive(1'b0, 0, 2'b00);
    tick();
    n_tests++;
    if ({s_ready, load_bank_1, load_bank_2, bank_loaded} !== 5'b10000 || cascade_in !== '0) begin
      n_fail++;
      $display("FAIL post_reset: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want rdy=1 rest 0",
               s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in);
    end
    tick();
    tick();
    n_tests++;
    if (cascade_in !== '0 || load_bank_1 !== 1'b0 || load_bank_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: got l1=%b l2=%b casc=%h, want 0 0 0",
               load_bank_1, load_bank_2, cascade_in);
    end
  endtask

  task automatic test_single();
    int ec [6];
    int el1 [6];
    int eld [6];
    ec  = '{0, 0, 1, 2, 3, 0};
    el1 = '{0, 1, 1, 1, 0, 0};
    eld = '{0, 0, 0, 0, 0, 1};
    do_reset();
    send_set(1, 2, 3);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({s_ready, load_bank_1, load_bank_2, bank_loaded} !== {1'b1, el1[i][0], 1'b0, eld[i][1:0]}
          || cascade_in !== rv(ec[i])) begin
        n_fail++;
        $display("FAIL single[%0d]: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want rdy=1 l1=%0d l2=0 loaded=%0d casc=%h",
                 i, s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in, el1[i], eld[i], rv(ec[i]));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int din [12];
    int esr [8];
    int el1 [8];
    int el2 [8];
    int ec  [8];
    int eld [8];
    din = '{0, 1, 2, 3, 4, 4, 4, 0, 0, 0, 0, 0};
    esr = '{1, 1, 0, 0, 0, 0, 0, 0};
    el1 = '{1, 1, 1, 0, 0, 0, 0, 0};
    el2 = '{0, 0, 0, 1, 1, 1, 0, 0};
    ec  = '{0, 1, 2, 3, 4, 4, 4, 0};
    eld = '{0, 0, 0, 0, 1, 1, 1, 3};
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      drive(c <= 6, din[c], 2'b00);
      tick();
      if (c >= 4) begin
        n_tests++;
        if ({s_ready, load_bank_1, load_bank_2, bank_loaded}
              !== {esr[c-4][0], el1[c-4][0], el2[c-4][0], eld[c-4][1:0]}
            || cascade_in !== rv(ec[c-4])) begin
          n_fail++;
          $display("FAIL b2b[edge %0d]: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want rdy=%0d l1=%0d l2=%0d loaded=%0d casc=%h",
                   c, s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in,
                   esr[c-4], el1[c-4], el2[c-4], eld[c-4], rv(ec[c-4]));
        end
      end
    end
    drive(1'b0, 0, 2'b00);
  endtask

  // Follows test_back_to_back: both banks LOADED, write pointer on bank 1.
  task automatic test_stall();
    int ec [6];
    int el1 [6];
    int eld [6];
    ec  = '{0, 0, 6, 7, 8, 0};
    el1 = '{0, 1, 1, 1, 0, 0};
    eld = '{2, 2, 2, 2, 2, 3};
    drive(1'b1, 6, 2'b00);
    tick();
    tick();
    n_tests++;
    if (s_ready !== 1'b0 || bank_loaded !== 2'b11) begin
      n_fail++;
      $display("FAIL stall: got rdy=%b loaded=%b, want rdy=0 loaded=11", s_ready, bank_loaded);
    end
    drive(1'b1, 6, 2'b01);
    tick();
    drive(1'b1, 6, 2'b00);
    n_tests++;
    if (s_ready !== 1'b1 || bank_loaded !== 2'b10) begin
      n_fail++;
      $display("FAIL release_ready: got rdy=%b loaded=%b, want rdy=1 loaded=10", s_ready, bank_loaded);
    end
    tick();
    drive(1'b1, 7, 2'b00); tick();
    drive(1'b1, 8, 2'b00); tick();
    drive(1'b0, 0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({s_ready, load_bank_1, load_bank_2, bank_loaded} !== {1'b0, el1[i][0], 1'b0, eld[i][1:0]}
          || cascade_in !== rv(ec[i])) begin
        n_fail++;
        $display("FAIL refill[%0d]: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want rdy=0 l1=%0d l2=0 loaded=%0d casc=%h",
                 i, s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in, el1[i], eld[i], rv(ec[i]));
      end
      tick();
    end
  endtask

  task automatic test_release_ignored();
    int din [12];
    din = '{0, 1, 2, 3, 4, 4, 4, 0, 0, 0, 0, 0};
    do_reset();
    // Bank 2 is LOADING from edge 7 through edge 10; release it at 9 and 10.
    for (int c = 1; c <= 11; c++) begin
      drive(c <= 6, din[c], (c == 9 || c == 10) ? 2'b10 : 2'b00);
      tick();
    end
    drive(1'b0, 0, 2'b00);
    n_tests++;
    if (bank_loaded !== 2'b11) begin
      n_fail++;
      $display("FAIL rel_loading: got loaded=%b, want 11", bank_loaded);
    end
    tick();
    tick();
    n_tests++;
    if (bank_loaded !== 2'b11) begin
      n_fail++;
      $display("FAIL rel_not_queued: got loaded=%b, want 11", bank_loaded);
    end
    drive(1'b0, 0, 2'b10);
    tick();
    drive(1'b0, 0, 2'b00);
    n_tests++;
    if (bank_loaded !== 2'b01 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_bank2: got loaded=%b rdy=%b, want loaded=01 rdy=0", bank_loaded, s_ready);
    end
  endtask

  task automatic test_reset_mid();
    int ec [6];
    int el [6];
    int eld1 [6];
    int eld2 [6];
    ec   = '{0, 0, 11, 12, 13, 0};
    el   = '{0, 1, 1, 1, 0, 0};
    eld1 = '{0, 0, 0, 0, 0, 1};
    eld2 = '{1, 1, 1, 1, 1, 3};
    do_reset();
    send_set(1, 2, 3);
    // Two rows of a partial set go into bank 2 while bank 1 is emitting.
    drive(1'b1, 20, 2'b00); tick();
    drive(1'b1, 21, 2'b00); tick();
    drive(1'b0, 0, 2'b00);  tick();
    n_tests++;
    if (load_bank_1 !== 1'b1 || cascade_in !== rv(2)) begin
      n_fail++;
      $display("FAIL mid_d1: got l1=%b casc=%h, want l1=1 casc=%h", load_bank_1, cascade_in, rv(2));
    end
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({s_ready, load_bank_1, load_bank_2, bank_loaded} !== 5'b0 || cascade_in !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want all 0",
               s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({s_ready, load_bank_1, load_bank_2, bank_loaded} !== 5'b10000 || cascade_in !== '0) begin
      n_fail++;
      $display("FAIL mid_after: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want rdy=1 rest 0",
               s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in);
    end
    send_set(11, 12, 13);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({s_ready, load_bank_1, load_bank_2, bank_loaded} !== {1'b1, el[i][0], 1'b0, eld1[i][1:0]}
          || cascade_in !== rv(ec[i])) begin
        n_fail++;
        $display("FAIL mid_bank1[%0d]: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want rdy=1 l1=%0d l2=0 loaded=%0d casc=%h",
                 i, s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in, el[i], eld1[i], rv(ec[i]));
      end
      tick();
    end
    // Bank 2 must start clean at row 0, not after the discarded partial rows.
    send_set(14, 15, 16);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({s_ready, load_bank_1, load_bank_2, bank_loaded} !== {1'b0, 1'b0, el[i][0], eld2[i][1:0]}
          || cascade_in !== rv((ec[i] == 0) ? 0 : ec[i] + 3)) begin
        n_fail++;
        $display("FAIL mid_bank2[%0d]: got rdy=%b l1=%b l2=%b loaded=%b casc=%h, want rdy=0 l1=0 l2=%0d loaded=%0d casc=%h",
                 i, s_ready, load_bank_1, load_bank_2, bank_loaded, cascade_in, el[i], eld2[i],
                 rv((ec[i] == 0) ? 0 : ec[i] + 3));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_release_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tensor_bank_loader.md
# tensor_bank_loader

Upstream feeder for the tensor-block column array (top), which takes 3 columns × 10 int8 lanes and produces 25-bit column results. It accepts weight rows over a valid/ready stream and buffers each bank's 3-row set. It then drives `load_bank_1`, `load_bank_2` and `cascade_in` with the exact contiguous load sequence the tensor blocks require, ping-ponging the two weight banks. Loads are back-to-back, with no gap.

## Interface
- `LANES`, 10: int8 lanes per row.
- `DW`, 8: lane width.
- `ROWS`, 3: rows per bank set, one per tensor column.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `s_valid` in 1: input row valid.
- `s_ready` out 1: row accepted when `s_valid && s_ready`.
- `s_data` in LANES*DW: row, lane 0 in bits [7:0].
- `bank_release` in 2: 1-cycle pulses from the compute side; bit 0 frees bank 1, bit 1 frees bank 2.
- `load_bank_1` out 1: bank-1 load strobe, to the tensor block.
- `load_bank_2` out 1: bank-2 load strobe.
- `cascade_in` out LANES*DW: row data to the tensor block.
- `bank_loaded` out 2: bank holds valid weights.

## Operation
- Each bank has a state: EMPTY → FILLING → PENDING → LOADING → LOADED → EMPTY.
- Fill side:
  - The write pointer `wr_bank` starts at bank 1.
  - `s_ready` = state[wr_bank] ∈ {EMPTY, FILLING}.
  - Accepted rows are stored at index 0..2.
  - Row 0 moves the bank to FILLING. Row 2 moves it to PENDING and toggles `wr_bank`.
- Emit side:
  - The read pointer `rd_bank` starts at bank 1 and issues strictly in alternating order.
  - A sequence starts when state[rd_bank] = PENDING and the emitter is IDLE or in its D2 phase. Starting moves that bank to LOADING.
  - The emitter FSM is IDLE → LEAD → D0 → D1 → D2 → (LEAD if the next bank is PENDING, else IDLE).
  - `load_bank_b` = 1 in LEAD, D0 and D1 (the strobe means "data arrives next cycle").
  - `cascade_in` = row0 in D0, row1 in D1, row2 in D2, and 0 in IDLE and LEAD-only cycles. When D2 overlaps with the next LEAD, `cascade_in` carries the old row2 while the other bank's strobe is 1.
  - On leaving D2 the bank becomes LOADED and `rd_bank` toggles.
- Release:
  - `bank_release[b]` in LOADED moves the bank to EMPTY.
  - A release in any other state is ignored, not queued.
- Simultaneous events:
  - An accept, an emit and a release in the same cycle all act independently.
  - A bank reaching EMPTY makes `s_ready` high in the next cycle.
- Reset, including mid-sequence:
  - All banks EMPTY, both pointers at bank 1, emitter IDLE.
  - Partial sets are discarded.
  - All outputs 0: `s_ready` is 0 during reset and 1 from the first cycle after reset.

## Timing
- All outputs are registered.
- Latency for an idle emitter: when row 2 is accepted at edge k, the strobe is high after edges k+1 to k+3, and row0/row1/row2 appear after edges k+2, k+3 and k+4.
- Back-to-back sets give a load period of 3 cycles. The second bank's LEAD coincides with the first bank's D2.
- Throughput is 1 row/cycle until both buffers are non-EMPTY. After that, input stalls until a release.
- The earliest refill of a released bank starts with a row accept in the cycle after the release.

## Structure
- `tensor_pkg` holds:
  - the constants `LANES`, `DW`, `ROWS`;
  - the `bank_state_t` enum (EMPTY, FILLING, PENDING, LOADING, LOADED);
  - the `emit_state_t` enum (IDLE, LEAD, D0, D1, D2);
  - a `row_t` type of LANES*DW bits.
- Sub-module `tensor_row_set_buf`: a 3-row register file with a write index, instantiated once per bank.
- The top holds both state machines, the pointers and the output registers.

## Test plan
- Reset then idle:
  - all outputs 0 during reset;
  - `s_ready` = 1 after reset;
  - `cascade_in` = 0 while idle.
- Single set, rows {10{8'd1}}, {10{8'd2}}, {10{8'd3}} accepted on consecutive cycles:
  - `load_bank_1` high for exactly 3 cycles;
  - `cascade_in` is 1, 2, 3 in the cycles following;
  - `load_bank_2` stays 0;
  - `bank_loaded` = 01.
- Two sets (1,2,3 then 4,4,4) streamed with no gaps:
  - `load_bank_2` rises in the same cycle that `cascade_in` = {10{8'd3}} and `load_bank_1` falls;
  - `bank_loaded` = 11;
  - `s_ready` = 0.
- Third set (6,7,8) offered with both banks LOADED:
  - the set stalls;
  - `bank_release` = 01 is followed by `s_ready` = 1 in the next cycle;
  - the set loads into bank 1, with `cascade_in` = 6, 7, 8.
- Release of bank 2 while it is LOADING:
  - the release is ignored;
  - bank 2 still reaches LOADED and still requires a later release.
- `rst_n` low during D1:
  - after the next edge all outputs are 0;
  - a new set then loads into bank 1 from row 0.
